shapool_job_loader: RTL and testbench



---
 rtl/shapool_job_loader.sv | 256 +++++++++++++++++++++++++
 tb/tb_shapool_job_loader.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/shapool_job_loader.sv
// shapool_job_loader: serial job-ingress front end for the shapool hashing pool.
// A 376-bit frame (sha_state, message_head, difficulty_bm, nonce_start_MSB, MSB
// first) arrives on cs_n/sck/sdi. It is oversampled in the clk domain and shifted
// into a staging register. A correctly sized frame is committed atomically to the
// job outputs, and the pool is then held in reset for RESET_HOLD cycles.
// Optional result read-back path: define SHAPOOL_LOADER_RESULT_EN.
module shapool_job_loader #(
  parameter int RESET_HOLD  = 4,
  parameter int NONCE_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   cs_n,
  input  logic                   sck,
  input  logic                   sdi,
  output logic                   sdo,
  input  logic                   success,
  input  logic [NONCE_WIDTH-1:0] nonce,
  output logic [255:0]           sha_state,
  output logic [95:0]            message_head,
  output logic [15:0]            difficulty_bm,
  output logic [7:0]             nonce_start_MSB,
  output logic                   pool_reset_n,
  output logic                   job_valid,
  output logic                   frame_error
);

  localparam logic [8:0] FRAME_LEN = 9'd376;
  localparam logic [8:0] OVERFLOW  = 9'd377;
  localparam int HOLD_W = (RESET_HOLD > 1) ? $clog2(RESET_HOLD) : 1;

  typedef enum logic [2:0] {
    IDLE,
    SHIFT,
    COMMIT,
    HOLD,
    RUN
  } state_t;

  state_t state;
  state_t next_state;

  logic cs_n_meta, cs_n_sync, cs_n_dly;
  logic sck_meta, sck_sync, sck_dly;
  logic sdi_meta, sdi_sync;

  logic cs_fall, cs_rise, sck_rise;

  logic [8:0]   bit_cnt;
  logic [375:0] shift_reg;

  logic              hold_active;
  logic [HOLD_W-1:0] hold_cnt;
  logic              hold_done;

  logic load_job, frame_bad, shift_en, clr_cnt;

  // Two-flop synchronisers plus one delay stage for edge detection on the serial pins
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cs_n_meta <= 1'b1;
      cs_n_sync <= 1'b1;
      cs_n_dly  <= 1'b1;
      sck_meta  <= 1'b0;
      sck_sync  <= 1'b0;
      sck_dly   <= 1'b0;
      sdi_meta  <= 1'b0;
      sdi_sync  <= 1'b0;
    end else begin
      cs_n_meta <= cs_n;
      cs_n_sync <= cs_n_meta;
      cs_n_dly  <= cs_n_sync;
      sck_meta  <= sck;
      sck_sync  <= sck_meta;
      sck_dly   <= sck_sync;
      sdi_meta  <= sdi;
      sdi_sync  <= sdi_meta;
    end
  end

  assign cs_fall  = cs_n_dly & ~cs_n_sync;
  assign cs_rise  = ~cs_n_dly & cs_n_sync;
  assign sck_rise = sck_sync & ~sck_dly;

  assign hold_done = hold_active && (hold_cnt == '0);

  // FSM state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= next_state;
  end

  // Next-state and datapath strobes; a coincident sck edge is dropped when cs_n rises
  always_comb begin
    next_state = state;
    load_job   = 1'b0;
    frame_bad  = 1'b0;
    shift_en   = 1'b0;
    clr_cnt    = 1'b0;
    case (state)
      IDLE, RUN: begin
        if (cs_fall) begin
          next_state = SHIFT;
          clr_cnt    = 1'b1;
        end
      end
      SHIFT: begin
        if (cs_rise) begin
          if (bit_cnt == FRAME_LEN) begin
            next_state = COMMIT;
            load_job   = 1'b1;
          end else begin
            frame_bad = 1'b1;
            if (hold_active)    next_state = HOLD;
            else if (job_valid) next_state = RUN;
            else                next_state = IDLE;
          end
        end else if (sck_rise) begin
          shift_en = 1'b1;
        end
      end
      COMMIT: begin
        if (cs_fall) begin
          next_state = SHIFT;
          clr_cnt    = 1'b1;
        end else if (hold_done) begin
          next_state = RUN;
        end else begin
          next_state = HOLD;
        end
      end
      HOLD: begin
        if (cs_fall) begin
          next_state = SHIFT;
          clr_cnt    = 1'b1;
        end else if (hold_done || !hold_active) begin
          next_state = RUN;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Bit counter (saturating at the overflow mark) and staging shift register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bit_cnt   <= '0;
      shift_reg <= '0;
    end else if (clr_cnt) begin
      bit_cnt <= '0;
    end else if (shift_en) begin
      shift_reg <= {shift_reg[374:0], sdi_sync};
      if (bit_cnt != OVERFLOW) bit_cnt <= bit_cnt + 9'd1;
    end
  end

  // Atomic commit of all job fields from the staging register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sha_state       <= '0;
      message_head    <= '0;
      difficulty_bm   <= '0;
      nonce_start_MSB <= '0;
    end else if (load_job) begin
      sha_state       <= shift_reg[375:120];
      message_head    <= shift_reg[119:24];
      difficulty_bm   <= shift_reg[23:8];
      nonce_start_MSB <= shift_reg[7:0];
    end
  end

  // Job status flags: job_valid is set by any commit, frame_error reflects the last frame
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      job_valid   <= 1'b0;
      frame_error <= 1'b0;
    end else if (load_job) begin
      job_valid   <= 1'b1;
      frame_error <= 1'b0;
    end else if (frame_bad) begin
      frame_error <= 1'b1;
    end
  end

  // Pool reset sequencer: runs independently of the FSM so a new frame can start mid-hold
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pool_reset_n <= 1'b0;
      hold_active  <= 1'b0;
      hold_cnt     <= '0;
    end else if (load_job) begin
      pool_reset_n <= 1'b0;
      hold_active  <= 1'b1;
      hold_cnt     <= HOLD_W'(RESET_HOLD - 1);
    end else if (hold_active) begin
      if (hold_cnt == '0) begin
        hold_active  <= 1'b0;
        pool_reset_n <= 1'b1;
      end else begin
        hold_cnt <= hold_cnt - HOLD_W'(1);
      end
    end
  end

`ifdef SHAPOOL_LOADER_RESULT_EN
  logic        sck_fall;
  logic        found;
  logic [31:0] res_nonce;
  logic [31:0] nonce_ext;
  logic [32:0] out_shift;
  logic [5:0]  out_cnt;

  assign sck_fall = ~sck_sync & sck_dly;

  // Zero-extend the pool nonce to the 32-bit result field
  always_comb begin
    nonce_ext = '0;
    nonce_ext[NONCE_WIDTH-1:0] = nonce;
  end

  // First success while the pool runs wins; a commit clears the result
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      found     <= 1'b0;
      res_nonce <= '0;
    end else if (load_job) begin
      found     <= 1'b0;
      res_nonce <= '0;
    end else if (!found && pool_reset_n && success) begin
      found     <= 1'b1;
      res_nonce <= nonce_ext;
    end
  end

  // Result snapshot on frame start, shifted out MSB first on sck falling edges
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_shift <= '0;
      out_cnt   <= '0;
    end else if (cs_fall) begin
      out_shift <= {found, res_nonce};
      out_cnt   <= 6'd33;
    end else if (sck_fall && !cs_n_sync && (out_cnt != 6'd0)) begin
      out_shift <= {out_shift[31:0], 1'b0};
      out_cnt   <= out_cnt - 6'd1;
    end
  end

  assign sdo = (!cs_n_sync && (out_cnt != 6'd0)) ? out_shift[32] : 1'b0;
`else
  logic unused_result_inputs;
  assign unused_result_inputs = &{1'b0, success, nonce};
  assign sdo = 1'b0;
`endif

endmodule

// File: tb/tb_shapool_job_loader.sv
// tb_shapool_job_loader: directed, table-driven bench for shapool_job_loader.
module tb_shapool_job_loader;

  logic         clk;
  logic         reset_n;
  logic         cs_n;
  logic         sck;
  logic         sdi;
  logic         sdo;
  logic         success;
  logic [31:0]  nonce;
  logic [255:0] sha_state;
  logic [95:0]  message_head;
  logic [15:0]  difficulty_bm;
  logic [7:0]   nonce_start_MSB;
  logic         pool_reset_n;
  logic         job_valid;
  logic         frame_error;

  int errors = 0;
  int checks = 0;

  typedef struct {
    int           nbits;
    logic [255:0] sha;
    logic [95:0]  head;
    logic [15:0]  diff;
    logic [7:0]   nmsb;
    logic         exp_commit;
    logic         exp_error;
  } vec_t;

  vec_t         vecs[6];
  vec_t         v;
  logic [399:0] bits;
  logic [255:0] exp_sha;
  logic [95:0]  exp_head;
  logic [15:0]  exp_diff;
  logic [7:0]   exp_nmsb;
  logic         exp_jv;
  logic         exp_err;
  logic         exp_prn;
  logic [32:0]  exp_result;

  shapool_job_loader #(
    .RESET_HOLD  (4),
    .NONCE_WIDTH (32)
  ) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .cs_n            (cs_n),
    .sck             (sck),
    .sdi             (sdi),
    .sdo             (sdo),
    .success         (success),
    .nonce           (nonce),
    .sha_state       (sha_state),
    .message_head    (message_head),
    .difficulty_bm   (difficulty_bm),
    .nonce_start_MSB (nonce_start_MSB),
    .pool_reset_n    (pool_reset_n),
    .job_valid       (job_valid),
    .frame_error     (frame_error)
  );

  // Free-running 100 MHz clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance n clock edges and settle 1 ns past the last one
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [255:0] actual, input logic [255:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  task automatic checkJob(input string tag);
    checkOutput({tag, ".sha_state"}, sha_state, exp_sha);
    checkOutput({tag, ".message_head"}, {160'd0, message_head}, {160'd0, exp_head});
    checkOutput({tag, ".difficulty_bm"}, {240'd0, difficulty_bm}, {240'd0, exp_diff});
    checkOutput({tag, ".nonce_start_MSB"}, {248'd0, nonce_start_MSB}, {248'd0, exp_nmsb});
    checkOutput({tag, ".job_valid"}, {255'd0, job_valid}, {255'd0, exp_jv});
    checkOutput({tag, ".frame_error"}, {255'd0, frame_error}, {255'd0, exp_err});
  endtask

  // Pool reset must be low on the commit cycle and three more, then released
  task automatic checkHold(input string tag);
    for (int k = 0; k < 4; k++) begin
      checkOutput($sformatf("%s.pool_reset_low%0d", tag, k), {255'd0, pool_reset_n}, 256'd0);
      tick(1);
    end
    checkOutput({tag, ".pool_reset_release"}, {255'd0, pool_reset_n}, 256'd1);
  endtask

  // Shift nbits MSB first from the top of the 400-bit vector, 6 clk per bit
  task automatic applyStimulus(input logic [399:0] data, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      sdi = data[399-i];
      tick(1);
      sck = 1'b1;
      tick(3);
      sck = 1'b0;
      tick(2);
    end
  endtask

  task automatic setExpected(input logic [255:0] s, input logic [95:0] h, input logic [15:0] d, input logic [7:0] n);
    exp_sha  = s;
    exp_head = h;
    exp_diff = d;
    exp_nmsb = n;
  endtask

  initial begin
    vecs[0] = '{376, {32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                      32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19},
                96'h1, 16'hFFFF, 8'hA5, 1'b1, 1'b0};
    vecs[1] = '{375, {32'hdeadbeef, 32'hcafebabe, 32'h01234567, 32'h89abcdef,
                      32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444},
                96'h0badf00d_0badf00d_0badf00d, 16'h1234, 8'h77, 1'b0, 1'b1};
    vecs[2] = '{376, 256'h0123456789abcdef_fedcba9876543210_0f1e2d3c4b5a6978_8796a5b4c3d2e1f0,
                96'hcafef00d_12345678_9abcdef0, 16'h00FF, 8'h3C, 1'b1, 1'b0};
    vecs[3] = '{400, {8{32'hffff0000}}, 96'h0, 16'hAAAA, 8'h11, 1'b0, 1'b1};
    vecs[4] = '{0, 256'd0, 96'd0, 16'd0, 8'd0, 1'b0, 1'b1};
    vecs[5] = '{376, {4{64'haaaaaaaa_55555555}}, 96'h80000000_00000000_00000001,
                16'h8001, 8'hFF, 1'b1, 1'b0};

    reset_n = 1'b0;
    cs_n    = 1'b1;
    sck     = 1'b0;
    sdi     = 1'b0;
    success = 1'b0;
    nonce   = 32'd0;
    setExpected('0, '0, '0, '0);
    exp_jv  = 1'b0;
    exp_err = 1'b0;
    exp_prn = 1'b0;

    tick(3);
    checkJob("reset");
    checkOutput("reset.pool_reset_n", {255'd0, pool_reset_n}, 256'd0);
    checkOutput("reset.sdo", {255'd0, sdo}, 256'd0);
    reset_n = 1'b1;
    tick(5);
    checkOutput("idle.pool_reset_n", {255'd0, pool_reset_n}, 256'd0);
    checkOutput("idle.job_valid", {255'd0, job_valid}, 256'd0);

    // Table of frames: good, short, good, long, empty, good
    for (int i = 0; i < 6; i++) begin
      string tag;
      tag  = $sformatf("vec%0d", i);
      v    = vecs[i];
      bits = {v.sha, v.head, v.diff, v.nmsb, 24'h5A5A5A};
      cs_n = 1'b0;
      tick(4);
      applyStimulus(bits, v.nbits);
      tick(2);
      cs_n = 1'b1;
      tick(2);
      checkOutput({tag, ".pre_commit_sha"}, sha_state, exp_sha);
      tick(1);
      if (v.exp_commit) begin
        setExpected(v.sha, v.head, v.diff, v.nmsb);
        exp_jv = 1'b1;
      end
      exp_err = v.exp_error;
      checkJob(tag);
      if (v.exp_commit) begin
        checkHold(tag);
        exp_prn = 1'b1;
      end else begin
        checkOutput({tag, ".pool_reset_n"}, {255'd0, pool_reset_n}, {255'd0, exp_prn});
      end
      checkOutput({tag, ".sdo_idle"}, {255'd0, sdo}, 256'd0);
      tick(3);
    end

    // Second frame started during the hold of the first
    cs_n = 1'b0;
    tick(4);
    applyStimulus({{8{32'h13579bdf}}, 96'h2468ace0_13579bdf_fedcba98, 16'h0F0F, 8'h01, 24'd0}, 376);
    tick(2);
    cs_n = 1'b1;
    tick(3);
    setExpected({8{32'h13579bdf}}, 96'h2468ace0_13579bdf_fedcba98, 16'h0F0F, 8'h01);
    exp_err = 1'b0;
    checkJob("hold1");
    checkOutput("hold1.pool_reset_low", {255'd0, pool_reset_n}, 256'd0);
    cs_n = 1'b0;
    tick(3);
    checkOutput("hold1.still_low_in_shift", {255'd0, pool_reset_n}, 256'd0);
    tick(1);
    checkOutput("hold1.release_in_shift", {255'd0, pool_reset_n}, 256'd1);
    applyStimulus({{8{32'h2468ace0}}, 96'h0, 16'h0001, 8'h80, 24'd0}, 376);
`ifndef SHAPOOL_LOADER_RESULT_EN
    checkOutput("hold2.sdo_disabled", {255'd0, sdo}, 256'd0);
`endif
    tick(2);
    cs_n = 1'b1;
    tick(3);
    setExpected({8{32'h2468ace0}}, 96'h0, 16'h0001, 8'h80);
    checkJob("hold2");
    checkHold("hold2");
    tick(3);

    // Reset pulsed in the middle of a frame
    cs_n = 1'b0;
    tick(4);
    applyStimulus({{8{32'h13579bdf}}, 96'h2468ace0_13579bdf_fedcba98, 16'h0F0F, 8'h01, 24'd0}, 200);
    reset_n = 1'b0;
    #2;
    setExpected('0, '0, '0, '0);
    exp_jv  = 1'b0;
    exp_err = 1'b0;
    checkJob("midreset");
    checkOutput("midreset.pool_reset_n", {255'd0, pool_reset_n}, 256'd0);
    checkOutput("midreset.sdo", {255'd0, sdo}, 256'd0);
    cs_n = 1'b1;
    sck  = 1'b0;
    tick(2);
    reset_n = 1'b1;
    tick(3);
    cs_n = 1'b0;
    tick(4);
    applyStimulus({{8{32'hc001d00d}}, 96'h11112222_33334444_55556666, 16'hF00F, 8'h5A, 24'd0}, 376);
    tick(2);
    cs_n = 1'b1;
    tick(3);
    setExpected({8{32'hc001d00d}}, 96'h11112222_33334444_55556666, 16'hF00F, 8'h5A);
    exp_jv = 1'b1;
    checkJob("postreset");
    checkHold("postreset");
    tick(4);

`ifdef SHAPOOL_LOADER_RESULT_EN
    // First success wins; the next frame reads {found, nonce} on sdo
    nonce   = 32'h00C0FFEE;
    success = 1'b1;
    tick(1);
    success = 1'b0;
    nonce   = 32'h1;
    tick(2);
    success = 1'b1;
    tick(1);
    success = 1'b0;
    nonce   = 32'h0;
    exp_result = {1'b1, 32'h00C0FFEE};
    cs_n = 1'b0;
    tick(4);
    for (int b = 32; b >= 0; b--) begin
      checkOutput($sformatf("result.sdo_bit%0d", b), {255'd0, sdo}, {255'd0, exp_result[b]});
      sck = 1'b1;
      tick(3);
      sck = 1'b0;
      tick(4);
    end
    checkOutput("result.sdo_after33", {255'd0, sdo}, 256'd0);
    cs_n = 1'b1;
    tick(4);
    checkOutput("result.sdo_cs_high", {255'd0, sdo}, 256'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
